// File: rtl/sram_arbiter.sv
// Two-client SRAM port arbiter: VGA scanout reads have priority over renderer reads/writes.
// Define SRAM_ARB_STARVE_GUARD_EN to let the renderer win after STARVE_LIMIT consecutive VGA grants.
module sram_arbiter #(
  parameter int unsigned ADDR_WIDTH    = 20,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned STARVE_LIMIT  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vga_req,
  input  logic [ADDR_WIDTH-1:0]   vga_addr,
  output logic                    vga_grant,
  output logic                    vga_rvalid,
  output logic [DATA_WIDTH-1:0]   vga_rdata,
  input  logic                    rnd_req,
  input  logic                    rnd_we,
  input  logic [ADDR_WIDTH-1:0]   rnd_addr,
  input  logic [DATA_WIDTH-1:0]   rnd_wdata,
  input  logic [DATA_WIDTH/8-1:0] rnd_be,
  output logic                    rnd_grant,
  output logic                    rnd_done,
  output logic [DATA_WIDTH-1:0]   rnd_rdata,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_dout,
  output logic                    sram_doe,
  input  logic [DATA_WIDTH-1:0]   sram_din,
  output logic [DATA_WIDTH/8-1:0] sram_be_n,
  output logic                    sram_ce_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] TURN  = 2'd3;

  if (ACCESS_CYCLES < 1 || STARVE_LIMIT < 1) begin : g_param_check
    $error("sram_arbiter: ACCESS_CYCLES and STARVE_LIMIT must be >= 1");
  end

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic                owner_rnd;
  logic [BE_WIDTH-1:0] be_q;
  logic                any_req;
  logic                pick_rnd;

  assign any_req = vga_req | rnd_req;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam int unsigned STK_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [STK_W-1:0] STK_MAX = STK_W'(STARVE_LIMIT);

  logic [STK_W-1:0] streak;

  assign pick_rnd = rnd_req & (~vga_req | (streak == STK_MAX));

  // Streak only moves on an arbitration; saturates so a stuck VGA cannot wrap it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak <= '0;
    end else if (state == IDLE && any_req) begin
      if (pick_rnd || !rnd_req) begin
        streak <= '0;
      end else if (streak != STK_MAX) begin
        streak <= streak + STK_W'(1);
      end
    end
  end
`else
  assign pick_rnd = rnd_req & ~vga_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      owner_rnd  <= 1'b0;
      be_q       <= '0;
      sram_addr  <= '0;
      sram_dout  <= '0;
      vga_rdata  <= '0;
      rnd_rdata  <= '0;
      vga_grant  <= 1'b0;
      rnd_grant  <= 1'b0;
      vga_rvalid <= 1'b0;
      rnd_done   <= 1'b0;
    end else begin
      vga_grant  <= 1'b0;
      rnd_grant  <= 1'b0;
      vga_rvalid <= 1'b0;
      rnd_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            cnt       <= '0;
            owner_rnd <= pick_rnd;
            vga_grant <= ~pick_rnd;
            rnd_grant <= pick_rnd;
            if (pick_rnd) begin
              sram_addr <= rnd_addr;
              sram_dout <= rnd_wdata;
              be_q      <= rnd_be;
              state     <= rnd_we ? WRITE : READ;
            end else begin
              sram_addr <= vga_addr;
              state     <= READ;
            end
          end
        end
        READ: begin
          if (cnt == LAST_CNT) begin
            state <= IDLE;
            if (owner_rnd) begin
              rnd_rdata <= sram_din;
              rnd_done  <= 1'b1;
            end else begin
              vga_rdata  <= sram_din;
              vga_rvalid <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          if (cnt == LAST_CNT) begin
            state    <= TURN;
            rnd_done <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    sram_be_n = '1;
    sram_doe  = 1'b0;
    case (state)
      READ: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_be_n = '0;
      end
      WRITE: begin
        sram_ce_n = 1'b0;
        sram_we_n = 1'b0;
        sram_be_n = ~be_q;
        sram_doe  = 1'b1;
      end
      TURN: begin
        sram_be_n = ~be_q;
        sram_doe  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter at default parameters.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        vga_req;
  logic [19:0] vga_addr;
  logic        vga_grant;
  logic        vga_rvalid;
  logic [31:0] vga_rdata;
  logic        rnd_req;
  logic        rnd_we;
  logic [19:0] rnd_addr;
  logic [31:0] rnd_wdata;
  logic [3:0]  rnd_be;
  logic        rnd_grant;
  logic        rnd_done;
  logic [31:0] rnd_rdata;
  logic [19:0] sram_addr;
  logic [31:0] sram_dout;
  logic        sram_doe;
  logic [31:0] sram_din;
  logic [3:0]  sram_be_n;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned vga_cnt;
  logic        seen;

  sram_arbiter #(
    .ADDR_WIDTH(20),
    .DATA_WIDTH(32),
    .ACCESS_CYCLES(2),
    .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_grant(vga_grant),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .rnd_req(rnd_req), .rnd_we(rnd_we), .rnd_addr(rnd_addr),
    .rnd_wdata(rnd_wdata), .rnd_be(rnd_be), .rnd_grant(rnd_grant),
    .rnd_done(rnd_done), .rnd_rdata(rnd_rdata),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_doe(sram_doe),
    .sram_din(sram_din), .sram_be_n(sram_be_n), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; vga_req = 1'b0; vga_addr = '0; rnd_req = 1'b0; rnd_we = 1'b0;
    rnd_addr = '0; rnd_wdata = '0; rnd_be = '0; sram_din = '0;

    // Reset held with clock running
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce_n", sram_ce_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_be_n", sram_be_n, 4'hF);
    chk("rst_doe", sram_doe, 0);
    chk("rst_grants", {vga_grant, rnd_grant}, 0);
    chk("rst_valids", {vga_rvalid, rnd_done}, 0);
    chk("rst_addr", sram_addr, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle_ce_n", sram_ce_n, 1);
    chk("post_rst_no_grant", vga_grant, 0);

    // Single VGA read
    vga_req = 1'b1; vga_addr = 20'h00100; sram_din = 32'hDEADBEEF;
    @(posedge clk); #1;
    chk("vr_grant", vga_grant, 1);
    chk("vr_rnd_grant", rnd_grant, 0);
    chk("vr_strobes_c0", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b001);
    chk("vr_be_n", sram_be_n, 4'h0);
    chk("vr_doe", sram_doe, 0);
    chk("vr_addr", sram_addr, 20'h00100);
    vga_req = 1'b0;
    @(posedge clk); #1;
    chk("vr_grant_pulse", vga_grant, 0);
    chk("vr_oe_n_c1", sram_oe_n, 0);
    chk("vr_rvalid_early", vga_rvalid, 0);
    @(posedge clk); #1;
    chk("vr_rvalid", vga_rvalid, 1);
    chk("vr_rdata", vga_rdata, 32'hDEADBEEF);
    chk("vr_idle_strobes", {sram_ce_n, sram_oe_n}, 2'b11);
    @(posedge clk); #1;
    chk("vr_rvalid_pulse", vga_rvalid, 0);

    // Renderer write
    rnd_req = 1'b1; rnd_we = 1'b1; rnd_addr = 20'h12345;
    rnd_wdata = 32'hA5A5A5A5; rnd_be = 4'b0011;
    @(posedge clk); #1;
    chk("wr_grant", rnd_grant, 1);
    chk("wr_strobes_c0", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b010);
    chk("wr_be_n", sram_be_n, 4'b1100);
    chk("wr_doe", sram_doe, 1);
    chk("wr_dout", sram_dout, 32'hA5A5A5A5);
    chk("wr_addr", sram_addr, 20'h12345);
    rnd_req = 1'b0;
    @(posedge clk); #1;
    chk("wr_we_n_c1", sram_we_n, 0);
    chk("wr_done_early", rnd_done, 0);
    @(posedge clk); #1;
    chk("wr_turn_done", rnd_done, 1);
    chk("wr_turn_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    chk("wr_turn_doe", sram_doe, 1);
    chk("wr_turn_hold", {sram_addr, sram_dout, sram_be_n}, {20'h12345, 32'hA5A5A5A5, 4'b1100});
    @(posedge clk); #1;
    chk("wr_idle_doe", sram_doe, 0);
    chk("wr_done_pulse", rnd_done, 0);

    // Simultaneous requests
    vga_req = 1'b1; vga_addr = 20'h00200; sram_din = 32'h11223344;
    rnd_req = 1'b1; rnd_we = 1'b0; rnd_addr = 20'h00055;
    @(posedge clk); #1;
    chk("sim_vga_first", {vga_grant, rnd_grant}, 2'b10);
    vga_req = 1'b0;
    @(posedge clk); #1;
    chk("sim_no_grant_mid", rnd_grant, 0);
    @(posedge clk); #1;
    chk("sim_vga_rvalid", vga_rvalid, 1);
    chk("sim_no_grant_idle", rnd_grant, 0);
    sram_din = 32'h99887766;
    @(posedge clk); #1;
    chk("sim_rnd_grant", rnd_grant, 1);
    chk("sim_rnd_addr", sram_addr, 20'h00055);
    rnd_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sim_rnd_done", rnd_done, 1);
    chk("sim_rnd_rdata", rnd_rdata, 32'h99887766);
    chk("sim_vga_rdata_kept", vga_rdata, 32'h11223344);

    // Continuous VGA pressure with renderer waiting
    vga_req = 1'b1; rnd_req = 1'b1; rnd_we = 1'b0; rnd_addr = 20'h00077;
    vga_cnt = 0; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      if (vga_grant) vga_cnt++;
      if (rnd_grant) seen = 1'b1;
    end
`ifdef SRAM_ARB_STARVE_GUARD_EN
    chk("starve_rnd_granted", seen, 1);
    chk("starve_vga_count", vga_cnt, 8);
`else
    chk("strict_no_rnd_grant", seen, 0);
    chk("strict_vga_count", vga_cnt, 20);
`endif
    vga_req = 1'b0; rnd_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("starve_drain_idle", sram_ce_n, 1);

    // Reset during second write cycle
    rnd_req = 1'b1; rnd_we = 1'b1; rnd_addr = 20'h00ABC;
    rnd_wdata = 32'h12345678; rnd_be = 4'hF;
    @(posedge clk); #1;
    chk("rw_grant", rnd_grant, 1);
    rnd_req = 1'b0;
    @(posedge clk); #1;
    chk("rw_we_n_c1", sram_we_n, 0);
    rst = 1'b0;
    #1;
    chk("rw_async_strobes", {sram_ce_n, sram_we_n}, 2'b11);
    chk("rw_async_doe", sram_doe, 0);
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (rnd_done) seen = 1'b1;
    end
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (rnd_done) seen = 1'b1;
    end
    chk("rw_no_done", seen, 0);
    vga_req = 1'b1; vga_addr = 20'h00300; sram_din = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("rw_fresh_grant", vga_grant, 1);
    chk("rw_fresh_addr", sram_addr, 20'h00300);
    vga_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rw_fresh_rvalid", vga_rvalid, 1);
    chk("rw_fresh_rdata", vga_rdata, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
